// File: rtl/multdiv_issue_ctrl.sv
`timescale 1ns/1ps
// Issue/writeback sequencer between execute and the multdiv unit.
// Optional BUSY watchdog enabled with the MULTDIV_TIMEOUT_EN macro.
module multdiv_issue_ctrl #(
   parameter int RSTATUS_REG    = 30,
   parameter int MUL_EXC_CODE   = 4,
   parameter int DIV_EXC_CODE   = 5,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic        flush,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic [4:0]  rd,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   output logic        md_is_div,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [4:0]  RSTATUS_RD = 5'(RSTATUS_REG);
   localparam logic [31:0] MUL_CODE   = 32'(MUL_EXC_CODE);
   localparam logic [31:0] DIV_CODE   = 32'(DIV_EXC_CODE);

   state_t      state;
   state_t      state_nx;
   logic [4:0]  rd_q;
   logic        ctrl_mult_q;
   logic        ctrl_div_q;
   logic        wb_valid_q;
   logic        accept;
   logic        timeout_hit;
   logic        finish_op;
   logic        cap_exc;

   assign accept = (state == S_IDLE) && (start_mult || start_div) && !flush;

`ifdef MULTDIV_TIMEOUT_EN
   logic [3:0] to_cnt;

   // Counts BUSY cycles; zero during the first BUSY cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= 4'd0;
      end else if (state != S_BUSY) begin
         to_cnt <= 4'd0;
      end else begin
         to_cnt <= to_cnt + 4'd1;
      end
   end

   assign timeout_hit = (state == S_BUSY) && !md_resultRDY &&
                        (to_cnt == 4'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Only the first RDY seen in BUSY completes the operation; a timeout forces the exception path.
   assign finish_op = (state == S_BUSY) && !flush && (md_resultRDY || timeout_hit);
   assign cap_exc   = md_resultRDY ? md_exception : 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_BUSY;
            S_BUSY:  if (finish_op) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         md_operandA <= 32'd0;
         md_operandB <= 32'd0;
         md_is_div   <= 1'b0;
         rd_q        <= 5'd0;
         ctrl_mult_q <= 1'b0;
         ctrl_div_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd       <= 5'd0;
         wb_data     <= 32'd0;
      end else begin
         ctrl_mult_q <= accept && !start_div;
         ctrl_div_q  <= accept && start_div;
         wb_valid_q  <= 1'b0;
         if (accept) begin
            md_operandA <= operand_a;
            md_operandB <= operand_b;
            md_is_div   <= start_div;
            rd_q        <= rd;
         end
         if (finish_op) begin
            if (cap_exc) begin
               wb_valid_q <= 1'b1;
               wb_rd      <= RSTATUS_RD;
               wb_data    <= md_is_div ? DIV_CODE : MUL_CODE;
            end else begin
               wb_valid_q <= (rd_q != 5'd0);
               wb_rd      <= rd_q;
               wb_data    <= md_result;
            end
         end
      end
   end

   // A flush in the pulse or writeback cycle still cancels that strobe.
   assign md_ctrl_MULT = ctrl_mult_q && !flush;
   assign md_ctrl_DIV  = ctrl_div_q && !flush;
   assign wb_valid     = wb_valid_q && !flush;

   assign stall     = accept || (state == S_ISSUE) || (state == S_BUSY);
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

endmodule
